ps2_key_encoder: RTL and testbench

- Receives PS/2 keyboard frames and decodes the arrow-key scancodes.
- Drives the 3-bit Key command bus read by the digger movement logic:
  - 001 up
  - 010 down
  - 011 left
  - 100 right
  - 000 idle
- Emits exactly one single-cycle Key pulse per accepted key press, so the consumer moves one cell per press.
- Sits between the board PS/2 pins and the game core.

---
 rtl/ps2_key_pkg.sv | 33 +++
 rtl/ps2_rx_frame.sv | 129 ++++++++++++
 rtl/ps2_key_encoder.sv | 94 +++++++++
 tb/tb_ps2_key_encoder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_pkg.sv
// Shared constants for the PS/2 arrow-key encoder: key codes, scancodes, and the rx frame state set.
package ps2_key_pkg;

  localparam int unsigned KEY_W  = 3;
  localparam int unsigned BYTE_W = 8;

  localparam logic [KEY_W-1:0] KEY_NONE  = 3'b000;
  localparam logic [KEY_W-1:0] KEY_UP    = 3'b001;
  localparam logic [KEY_W-1:0] KEY_DOWN  = 3'b010;
  localparam logic [KEY_W-1:0] KEY_LEFT  = 3'b011;
  localparam logic [KEY_W-1:0] KEY_RIGHT = 3'b100;

  localparam logic [BYTE_W-1:0] SC_EXT   = 8'hE0;
  localparam logic [BYTE_W-1:0] SC_BRK   = 8'hF0;
  localparam logic [BYTE_W-1:0] SC_UP    = 8'h75;
  localparam logic [BYTE_W-1:0] SC_DOWN  = 8'h72;
  localparam logic [BYTE_W-1:0] SC_LEFT  = 8'h6B;
  localparam logic [BYTE_W-1:0] SC_RIGHT = 8'h74;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;

  // Extended-set arrow scancode to key code; anything else maps to KEY_NONE.
  function automatic logic [KEY_W-1:0] arrow_code(input logic [BYTE_W-1:0] sc);
    case (sc)
      SC_UP:    arrow_code = KEY_UP;
      SC_DOWN:  arrow_code = KEY_DOWN;
      SC_LEFT:  arrow_code = KEY_LEFT;
      SC_RIGHT: arrow_code = KEY_RIGHT;
      default:  arrow_code = KEY_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, 11-bit frame FSM and mid-frame watchdog.
module ps2_rx_frame
  import ps2_key_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned TW             = 13
) (
  input  logic              Clk,
  input  logic              rst,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  output logic [BYTE_W-1:0] code,
  output logic              code_valid,
  output logic              frame_err
);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;
  logic                   timeout;

  rx_state_e         state, state_nxt;
  logic [BYTE_W-1:0] shift, shift_nxt;
  logic [2:0]        bit_cnt, bit_cnt_nxt;
  logic              par_ok, par_ok_nxt;
  logic [TW-1:0]     wd, wd_nxt;
  logic [BYTE_W-1:0] code_nxt;
  logic              code_valid_nxt;
  logic              frame_err_nxt;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = clk_prev & ~clk_s;

  // Synchronizers idle high so reset never fabricates a falling edge.
  always_ff @(posedge Clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_s;
    end
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      par_ok     <= 1'b0;
      wd         <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift      <= shift_nxt;
      bit_cnt    <= bit_cnt_nxt;
      par_ok     <= par_ok_nxt;
      wd         <= wd_nxt;
      code       <= code_nxt;
      code_valid <= code_valid_nxt;
      frame_err  <= frame_err_nxt;
    end
  end

  // A fall in the expiry cycle keeps the frame alive, so timeout requires no fall.
  assign timeout = (state != IDLE) && !fall && (wd == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt      = state;
    shift_nxt      = shift;
    bit_cnt_nxt    = bit_cnt;
    par_ok_nxt     = par_ok;
    code_nxt       = code;
    code_valid_nxt = 1'b0;
    frame_err_nxt  = 1'b0;

    if (state == IDLE || fall) wd_nxt = '0;
    else                       wd_nxt = wd + TW'(1);

    case (state)
      IDLE: begin
        if (fall && !data_s) begin
          state_nxt   = DATA;
          bit_cnt_nxt = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_nxt   = {data_s, shift[BYTE_W-1:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_ok_nxt = ^{shift, data_s};
          state_nxt  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          if (par_ok && data_s) begin
            code_nxt       = shift;
            code_valid_nxt = 1'b1;
          end else begin
            frame_err_nxt  = 1'b1;
          end
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (timeout) begin
      state_nxt     = IDLE;
      frame_err_nxt = 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 arrow-key encoder: E0/F0 prefix tracking, arrow decode, held-key tracking, one-cycle Key pulses.
// Build option: define PS2_TYPEMATIC_EN to let a repeated make of the held key emit Key again.
module ps2_key_encoder
  import ps2_key_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned TW             = 13
) (
  input  logic       Clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [2:0] Key,
  output logic       frame_err,
  output logic [2:0] held
);

  logic [BYTE_W-1:0] code;
  logic              code_valid;
  logic [KEY_W-1:0]  arrow;
  logic              ext, ext_nxt;
  logic              brk, brk_nxt;
  logic [KEY_W-1:0]  key_nxt;
  logic [KEY_W-1:0]  held_nxt;

  ps2_rx_frame #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TW            (TW)
  ) u_rx (
    .Clk       (Clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .code      (code),
    .code_valid(code_valid),
    .frame_err (frame_err)
  );

  assign arrow = arrow_code(code);

  always_ff @(posedge Clk) begin
    if (rst) begin
      ext  <= 1'b0;
      brk  <= 1'b0;
      Key  <= KEY_NONE;
      held <= KEY_NONE;
    end else begin
      ext  <= ext_nxt;
      brk  <= brk_nxt;
      Key  <= key_nxt;
      held <= held_nxt;
    end
  end

  // Prefix bytes only arm flags; the next non-prefix byte consumes and clears them.
  always_comb begin
    ext_nxt  = ext;
    brk_nxt  = brk;
    key_nxt  = KEY_NONE;
    held_nxt = held;

    if (frame_err) begin
      ext_nxt = 1'b0;
      brk_nxt = 1'b0;
    end else if (code_valid) begin
      if (code == SC_EXT) begin
        ext_nxt = 1'b1;
      end else if (code == SC_BRK) begin
        brk_nxt = 1'b1;
      end else begin
        if (ext && arrow != KEY_NONE) begin
          if (!brk) begin
`ifdef PS2_TYPEMATIC_EN
            key_nxt  = arrow;
            held_nxt = arrow;
`else
            if (arrow != held) begin
              key_nxt  = arrow;
              held_nxt = arrow;
            end
`endif
          end else if (arrow == held) begin
            held_nxt = KEY_NONE;
          end
        end
        ext_nxt = 1'b0;
        brk_nxt = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Bench for ps2_key_encoder: PS/2 frames driven on the pins, checked against a per-byte behavioural model.
module tb_ps2_key_encoder;

  logic       Clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [2:0] Key;
  logic       frame_err;
  logic [2:0] held;

`ifdef PS2_TYPEMATIC_EN
  localparam bit TYPEMATIC = 1'b1;
`else
  localparam bit TYPEMATIC = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] obs_q[$];
  logic [2:0] exp_q[$];
  int         err_cnt = 0;
  int         exp_err = 0;
  int         consec = 0;
  logic [2:0] prev_key = 3'b000;

  bit         m_ext, m_brk;
  logic [2:0] m_held;

  always #5 Clk = ~Clk;

  ps2_key_encoder #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(5000),
    .TW            (13)
  ) dut (
    .Clk      (Clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .Key      (Key),
    .frame_err(frame_err),
    .held     (held)
  );

  // Observer: collects Key pulses, frame_err pulses and back-to-back Key cycles.
  always @(negedge Clk) begin
    if (!rst) begin
      if (Key !== 3'b000) begin
        obs_q.push_back(Key);
        if (prev_key !== 3'b000) consec++;
      end
      if (frame_err === 1'b1) err_cnt++;
    end
    prev_key = Key;
  end

  function automatic logic [2:0] ref_map(input logic [7:0] b);
    case (b)
      8'h75:   return 3'd1;
      8'h72:   return 3'd2;
      8'h6B:   return 3'd3;
      8'h74:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Reference: what a keyboard byte (good or corrupted) means to the consumer.
  task automatic model_byte(input logic [7:0] b, input bit good);
    logic [2:0] c;
    if (!good) begin
      exp_err++;
      m_ext = 0;
      m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      c = ref_map(b);
      if (m_ext && c != 3'd0) begin
        if (!m_brk) begin
          if (c != m_held || TYPEMATIC) begin
            exp_q.push_back(c);
            m_held = c;
          end
        end else if (c == m_held) begin
          m_held = 3'd0;
        end
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_clk(8);
    ps2_clk = 1'b0;
    wait_clk(12);
    ps2_clk = 1'b1;
    wait_clk(8);
  endtask

  task automatic send(input logic [7:0] b, input bit bad_par);
    model_byte(b, !bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(1'b1);
    wait_clk(20);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
    obs_q.delete();
    exp_q.delete();
    err_cnt = 0;
    exp_err = 0;
    consec = 0;
    m_ext = 0;
    m_brk = 0;
    m_held = 3'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clk(3);
    n_cmp++; if (Key !== 3'b000) begin n_bad++; $display("FAIL reset_key got %b want 000", Key); end
    n_cmp++; if (held !== 3'b000) begin n_bad++; $display("FAIL reset_held got %b want 000", held); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", frame_err); end
    do_reset();
  endtask

  task automatic test_press();
    do_reset();
    send(8'hE0, 0);
    send(8'h75, 0);
    n_cmp++; if (obs_q.size() != 1 || obs_q[0] !== 3'b001) begin n_bad++; $display("FAIL press_key got %0d pulses first %b want 1 pulse 001", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 3'bxxx); end
    n_cmp++; if (held !== 3'b001) begin n_bad++; $display("FAIL press_held got %b want 001", held); end
    n_cmp++; if (err_cnt != 0) begin n_bad++; $display("FAIL press_err got %0d want 0", err_cnt); end
    n_cmp++; if (consec != 0) begin n_bad++; $display("FAIL press_width got %0d wide pulses want 0", consec); end
  endtask

  task automatic test_repeat();
    do_reset();
    send(8'hE0, 0); send(8'h6B, 0);
    send(8'hE0, 0); send(8'h6B, 0);
    n_cmp++; if (obs_q.size() != (TYPEMATIC ? 2 : 1)) begin n_bad++; $display("FAIL repeat_count got %0d want %0d", obs_q.size(), TYPEMATIC ? 2 : 1); end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== 3'b011) begin n_bad++; $display("FAIL repeat_key[%0d] got %b want 011", i, obs_q[i]); end
    end
    n_cmp++; if (held !== 3'b011) begin n_bad++; $display("FAIL repeat_held got %b want 011", held); end
  endtask

  task automatic test_break();
    do_reset();
    send(8'hE0, 0); send(8'h72, 0);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h72, 0);
    n_cmp++; if (held !== 3'b000) begin n_bad++; $display("FAIL break_held got %b want 000", held); end
    n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL break_count got %0d want 1", obs_q.size()); end
    send(8'hE0, 0); send(8'h72, 0);
    n_cmp++; if (obs_q.size() != 2 || obs_q[1] !== 3'b010) begin n_bad++; $display("FAIL break_repress got %0d pulses want 2 ending 010", obs_q.size()); end
    n_cmp++; if (held !== 3'b010) begin n_bad++; $display("FAIL break_reheld got %b want 010", held); end
  endtask

  task automatic test_parity_err();
    do_reset();
    send(8'hE0, 0);
    send(8'h75, 1);
    n_cmp++; if (err_cnt != 1) begin n_bad++; $display("FAIL parity_err got %0d want 1", err_cnt); end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL parity_nokey got %0d pulses want 0", obs_q.size()); end
    send(8'hE0, 0); send(8'h74, 0);
    n_cmp++; if (obs_q.size() != 1 || obs_q[0] !== 3'b100) begin n_bad++; $display("FAIL parity_recover got %0d pulses want 1 of 100", obs_q.size()); end
  endtask

  task automatic test_timeout();
    do_reset();
    send(8'hE0, 0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    wait_clk(5100);
    exp_err++; m_ext = 0; m_brk = 0;
    n_cmp++; if (err_cnt != 1) begin n_bad++; $display("FAIL timeout_err got %0d want 1", err_cnt); end
    send(8'h75, 0);
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL timeout_extclr got %0d pulses want 0", obs_q.size()); end
    send(8'hE0, 0); send(8'h75, 0);
    n_cmp++; if (obs_q.size() != 1 || obs_q[0] !== 3'b001) begin n_bad++; $display("FAIL timeout_recover got %0d pulses want 1 of 001", obs_q.size()); end
    n_cmp++; if (err_cnt != exp_err) begin n_bad++; $display("FAIL timeout_errtotal got %0d want %0d", err_cnt, exp_err); end
  endtask

  task automatic test_reset_midframe();
    int bad_in_rst;
    do_reset();
    send(8'hE0, 0);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    rst = 1'b1;
    bad_in_rst = 0;
    for (int i = 0; i < 5; i++) begin
      wait_clk(1);
      if (Key !== 3'b000 || held !== 3'b000 || frame_err !== 1'b0) bad_in_rst++;
    end
    n_cmp++; if (bad_in_rst != 0) begin n_bad++; $display("FAIL midrst_outputs got %0d active cycles want 0", bad_in_rst); end
    do_reset();
    send(8'hE0, 0); send(8'h74, 0);
    n_cmp++; if (obs_q.size() != 1 || obs_q[0] !== 3'b100) begin n_bad++; $display("FAIL midrst_key got %0d pulses want 1 of 100", obs_q.size()); end
    n_cmp++; if (held !== 3'b100) begin n_bad++; $display("FAIL midrst_held got %b want 100", held); end
    n_cmp++; if (err_cnt != 0) begin n_bad++; $display("FAIL midrst_err got %0d want 0", err_cnt); end
  endtask

  task automatic test_random();
    logic [7:0] pool [8];
    pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1C, 8'hE0};
    do_reset();
    for (int i = 0; i < 60; i++) begin
      send(pool[$urandom_range(0, 7)], ($urandom_range(0, 9) == 0));
    end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL random_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL random_key[%0d] got %b want %b", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (err_cnt != exp_err) begin n_bad++; $display("FAIL random_err got %0d want %0d", err_cnt, exp_err); end
    n_cmp++; if (held !== m_held) begin n_bad++; $display("FAIL random_held got %b want %b", held, m_held); end
    n_cmp++; if (consec != 0) begin n_bad++; $display("FAIL random_width got %0d wide pulses want 0", consec); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_repeat();
    test_break();
    test_parity_err();
    test_timeout();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
